ahb_slave_responder: RTL
========================

Name: ahb_slave_responder

Overview:
- AHB slave-side responder: the endpoint behind a slave port that the master-side address decoders select via hreq/hsel.
- Accepts address phases and services them from an internal word-addressed register array.
- Drives hreadyout, hresp and hrdata, including the two-cycle ERROR response for illegal accesses.
- Used as a generic memory-mapped slave and as a reference responder for bench bring-up.

Parameters:
AHB_ADDR_WIDTH, 32, width of haddr
AHB_DATA_WIDTH, 32, width of hwdata/hrdata; fixed at 32 for this version
MEM_DEPTH, 256, number of 32-bit words in the array; power of two
WAIT_STATES, 2, data-phase wait cycles per OKAY transfer, range 0..15; used only when AHB_SLV_WAIT_EN is defined

Ports:
hclk  input  1  bus clock, all logic on rising edge
hreset_n  input  1  synchronous active-low reset
hsel  input  1  slave select from the decoder/interconnect
haddr  input  AHB_ADDR_WIDTH  byte address
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11 (htrans_type)
hwrite  input  1  1=write, 0=read
hsize  input  3  000 byte, 001 halfword, 010 word; larger values are illegal
hwdata  input  32  write data, valid in the data phase
hready_in  input  1  bus hready, high means the previous transfer completes this cycle
hreadyout  output  1  slave ready
hresp  output  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven
hrdata  output  32  read data, valid when hreadyout=1 and hresp=OKAY

Behaviour:
- Reset: one hclk edge with hreset_n=0 takes effect. After reset: hreadyout=1, hresp=OKAY, hrdata=0, FSM=IDLE, wait counter=0, no pending write. Array contents are not reset. Reset mid-transfer discards the pending write and any wait or error state.
- Address phase accepted when hsel & hready_in & htrans[1] are all 1 on a rising edge. The slave then registers haddr, hwrite, hsize and the legality result.
- Legal access requires all three of:
  - hsize <= 010;
  - alignment: haddr[0]=0 for halfword, haddr[1:0]=00 for word;
  - word index haddr[AHB_ADDR_WIDTH-1:2] < MEM_DEPTH. No aliasing.
- BUSY, IDLE, or hsel=0 with hready_in=1: no transfer. The next cycle gives a zero-wait OKAY with no array effect.
- FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
  - IDLE/DATA, legal capture: go to WAIT if the effective wait count > 0, else DATA.
  - IDLE/DATA, illegal capture: go to ERR1.
  - IDLE/DATA, no capture: go to IDLE.
  - WAIT: hreadyout=0, hresp=OKAY, counter decrements. Go to DATA after the count expires.
  - DATA: hreadyout=1, hresp=OKAY. The transfer completes; a new capture may occur on the same edge.
  - ERR1: hreadyout=0, hresp=ERROR. Next state is always ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. A capture on this edge is handled as in IDLE, since the master may have already issued or cancelled the next address.
- Read timing:
  - hrdata is registered.
  - Zero-wait: loaded on the capture edge from the array.
  - With waits: loaded on the edge entering DATA.
  - The full word is returned; byte lanes are selected by the master.
  - hrdata holds its last value otherwise.
- Write timing:
  - hwdata is sampled on the edge that ends the DATA cycle.
  - Only byte lanes given by hsize/haddr[1:0] are written (little-endian). Examples: byte at addr[1:0]=10 writes bits 23:16; halfword at 10 writes bits 31:16.
  - Erroring writes never modify the array.
- Read-after-write hazard: if a read is captured on the same edge a write commits to the same word, hrdata returns the merged new data (forwarding). Zero-wait back-to-back W then R must see the new value.
- hready_in=0 while in IDLE/DATA blocks capture and does not disturb the slave's own response.

Optional Feature:
- AHB_SLV_WAIT_EN defined: every legal transfer, read or write, inserts WAIT_STATES cycles of hreadyout=0/OKAY before DATA. The counter is 4 bits.
- Not defined: the effective wait count is 0, the WAIT state and counter are not synthesized, and WAIT_STATES is ignored. Every legal transfer completes in one data-phase cycle.
- ERROR responses are two cycles in both builds.

Test Plan:
- Reset with hreset_n=0 for 2 cycles, then release -> hreadyout=1, hresp=00, hrdata=0 in the first cycle after release.
- Zero-wait (macro off): NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ word read 0x10 back-to-back -> read data phase hrdata=0xDEADBEEF, hreadyout=1 (forwarding path).
- Byte write 0xAA to 0x12 over word 0x11223344 at 0x10, then word read -> 0x11AA3344.
- Word read at 0x400 with MEM_DEPTH=256 (index 256) -> cycle1 hreadyout=0/hresp=01, cycle2 hreadyout=1/hresp=01. A following legal read at 0x0 captured in cycle2 completes OKAY.
- Misaligned halfword write at 0x01 -> two-cycle ERROR, and array word 0 unchanged on readback.
- Macro on, WAIT_STATES=2: word read at 0x20 -> 2 cycles hreadyout=0/OKAY, then hreadyout=1 with correct data. hsel=1 with htrans=BUSY -> OKAY with no waits.

Source files
------------

// File: rtl/ahb_slave_responder.sv
// AHB slave responder backed by a word-addressed register array with OKAY/ERROR responses.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles before every legal data phase.
module ahb_slave_responder #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned WAIT_STATES    = 2
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready_in,
  output logic                      hreadyout,
  output logic [1:0]                hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata
);

  localparam int unsigned IdxW      = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespError = 2'b01;

  typedef enum logic [2:0] {StIdle, StData, StWait, StErr1, StErr2} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           act_idx_q;
  logic [1:0]                lane_q;
  logic [1:0]                size_q;
  logic                      write_q;
  logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

`ifdef AHB_SLV_WAIT_EN
  localparam int unsigned WaitCnt = WAIT_STATES;
  logic [3:0] wcnt_q;
`else
  localparam int unsigned unused_wait_states = WAIT_STATES;
`endif

  logic unused_htrans;
  assign unused_htrans = htrans[0];

  logic            can_capture, capture, size_ok, align_ok, range_ok, legal;
  logic [IdxW-1:0] cap_idx;

  // Captures are only possible while this slave is driving hreadyout high.
  assign can_capture = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign capture     = can_capture && hsel && hready_in && htrans[1];
  assign size_ok     = (hsize <= 3'b010);
  assign range_ok    = ((haddr >> (IdxW + 2)) == '0);
  assign legal       = size_ok && align_ok && range_ok;
  assign cap_idx     = haddr[IdxW+1:2];

  always_comb begin
    align_ok = 1'b1;
    case (hsize)
      3'b001:  align_ok = ~haddr[0];
      3'b010:  align_ok = (haddr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  logic                      commit, fwd_hit;
  logic [3:0]                be;
  logic [AHB_DATA_WIDTH-1:0] merged, rd_word;

  assign commit = hreset_n && (state_q == StData) && write_q;

  always_comb begin
    be = 4'b1111;
    case (size_q)
      2'b00:   be = 4'b0001 << lane_q;
      2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    merged = mem[act_idx_q];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  // A read captured on the edge a write commits to the same word sees the merged data.
  assign fwd_hit = commit && (act_idx_q == cap_idx);
  assign rd_word = fwd_hit ? merged : mem[cap_idx];

  always_ff @(posedge hclk) begin
    if (commit) mem[act_idx_q] <= merged;
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q   <= StIdle;
      hreadyout <= 1'b1;
      hresp     <= RespOkay;
      hrdata    <= '0;
      act_idx_q <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      wcnt_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StData, StErr2: begin
          if (capture) begin
            act_idx_q <= cap_idx;
            lane_q    <= haddr[1:0];
            size_q    <= hsize[1:0];
            write_q   <= hwrite;
            if (!legal) begin
              state_q   <= StErr1;
              hreadyout <= 1'b0;
              hresp     <= RespError;
              write_q   <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
            end else if (WaitCnt != 0) begin
              state_q   <= StWait;
              hreadyout <= 1'b0;
              hresp     <= RespOkay;
              wcnt_q    <= 4'(WaitCnt - 1);
`endif
            end else begin
              state_q   <= StData;
              hreadyout <= 1'b1;
              hresp     <= RespOkay;
              if (!hwrite) hrdata <= rd_word;
            end
          end else begin
            state_q   <= StIdle;
            hreadyout <= 1'b1;
            hresp     <= RespOkay;
            write_q   <= 1'b0;
          end
        end
        StWait: begin
`ifdef AHB_SLV_WAIT_EN
          if (wcnt_q == 4'd0) begin
            state_q   <= StData;
            hreadyout <= 1'b1;
            hresp     <= RespOkay;
            if (!write_q) hrdata <= mem[act_idx_q];
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
`else
          state_q   <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= RespOkay;
`endif
        end
        StErr1: begin
          state_q   <= StErr2;
          hreadyout <= 1'b1;
          hresp     <= RespError;
        end
        default: begin
          state_q   <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= RespOkay;
        end
      endcase
    end
  end

endmodule
